// File: rtl/pc_fetch_stage.sv
// Fetch stage behind the hazard PC-select mux.
// Owns the fetch PC, the instruction-memory request/ready handshake and the IF/ID register.
// A word that returns during a stall is parked in hold_q.
// A request still outstanding at a redirect is drained before the new address is issued.
module pc_fetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_INC    = 4,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [31:0]       ifid_instr_o,
    output logic              ifid_valid_o,
    output logic              fetch_busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       hold_q, hold_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;

    // Next-state decode; flush outranks stall in every state and always redirects to pc_next_i.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        hold_d       = hold_q;
        drain_addr_d = drain_addr_q;

        if (flush_i) begin
            pc_d         = pc_next_i;
            ifid_pc_d    = pc_next_i;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (flush_i) begin
                    // An unanswered request must still complete; remember its address.
                    if (!imem_ready_i) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ready_i) begin
                    if (!stall_i) begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = imem_rdata_i;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_next_i;
                    end else begin
                        hold_d  = imem_rdata_i;
                        state_d = HOLD;
                    end
                end else if (!stall_i) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = FETCH;
                end else if (!stall_i) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = hold_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_next_i;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ready_i) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, fetch PC and IF/ID register; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Stall buffer and drain address are only read in the states that load them, so no reset.
    always_ff @(posedge clk) begin
        hold_q       <= hold_d;
        drain_addr_q <= drain_addr_d;
    end

    // Outputs are decoded from registered state; only fetch_busy_o also looks at ready.
    always_comb begin
        imem_req_o   = (state_q == FETCH) || (state_q == DRAIN);
        imem_addr_o  = (state_q == DRAIN) ? drain_addr_q : pc_q;
        fetch_busy_o = (state_q == IDLE) || (state_q == DRAIN) ||
                       ((state_q == FETCH) && !imem_ready_i);
        pc_o         = pc_q;
        pc_plus4_o   = pc_q + ADDR_W'(PC_INC);
        ifid_pc_o    = ifid_pc_q;
        ifid_instr_o = ifid_instr_q;
        ifid_valid_o = ifid_valid_q;
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a per-cycle vector table plus hand sequences
// for mid-wait reset and PC wrap-around.
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_next_i;
    logic        stall_i;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        fetch_busy_o;

    int checks = 0;
    int failures = 0;

    pc_fetch_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .PC_INC   (4),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_next_i   (pc_next_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ready_i(imem_ready_i),
        .imem_rdata_i(imem_rdata_i),
        .pc_o        (pc_o),
        .pc_plus4_o  (pc_plus4_o),
        .ifid_pc_o   (ifid_pc_o),
        .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o),
        .fetch_busy_o(fetch_busy_o)
    );

    always #5 clk = ~clk;

    // One cycle: inputs applied during the cycle, outputs expected in that same cycle.
    typedef struct {
        logic [31:0] pc_next;
        logic        stall;
        logic        flush;
        logic        ready;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] pn, logic st, logic fl, logic rd, logic [31:0] rdat,
                                logic rq, logic [31:0] ad, logic bz, logic [31:0] pc,
                                logic v, logic [31:0] ipc, logic [31:0] ins);
        vec_t t;
        t.pc_next = pn; t.stall = st; t.flush = fl; t.ready = rd; t.rdata = rdat;
        t.e_req = rq; t.e_addr = ad; t.e_busy = bz; t.e_pc = pc;
        t.e_v = v; t.e_ifpc = ipc; t.e_instr = ins;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pn, input logic st, input logic fl,
                         input logic rd, input logic [31:0] rdat);
        pc_next_i = pn; stall_i = st; flush_i = fl; imem_ready_i = rd; imem_rdata_i = rdat;
    endtask

    initial begin
        // pc_next, stall, flush, ready, rdata | req, addr, busy, pc, ifid_v, ifid_pc, ifid_instr
        // Straight-line fetch from reset
        vecs.push_back(mk(32'h004, 0, 0, 1, 32'h0,         0, 32'h000, 1, 32'h000, 0, 32'h000, NOP));
        vecs.push_back(mk(32'h004, 0, 0, 1, 32'h1000_0000, 1, 32'h000, 0, 32'h000, 0, 32'h000, NOP));
        vecs.push_back(mk(32'h008, 0, 0, 1, 32'h1000_0004, 1, 32'h004, 0, 32'h004, 1, 32'h000, 32'h1000_0000));
        vecs.push_back(mk(32'h00C, 0, 0, 1, 32'h1000_0008, 1, 32'h008, 0, 32'h008, 1, 32'h004, 32'h1000_0004));
        vecs.push_back(mk(32'h010, 0, 0, 1, 32'h1000_000C, 1, 32'h00C, 0, 32'h00C, 1, 32'h008, 32'h1000_0008));
        // Memory wait at 0x10 for three cycles
        vecs.push_back(mk(32'h014, 0, 0, 0, 32'h0,         1, 32'h010, 1, 32'h010, 1, 32'h00C, 32'h1000_000C));
        vecs.push_back(mk(32'h014, 0, 0, 0, 32'h0,         1, 32'h010, 1, 32'h010, 0, 32'h00C, NOP));
        vecs.push_back(mk(32'h014, 0, 0, 0, 32'h0,         1, 32'h010, 1, 32'h010, 0, 32'h00C, NOP));
        vecs.push_back(mk(32'h014, 0, 0, 1, 32'h1000_0010, 1, 32'h010, 0, 32'h010, 0, 32'h00C, NOP));
        vecs.push_back(mk(32'h018, 0, 0, 1, 32'h1000_0014, 1, 32'h014, 0, 32'h014, 1, 32'h010, 32'h1000_0010));
        vecs.push_back(mk(32'h01C, 0, 0, 1, 32'h1000_0018, 1, 32'h018, 0, 32'h018, 1, 32'h014, 32'h1000_0014));
        vecs.push_back(mk(32'h020, 0, 0, 1, 32'h1000_001C, 1, 32'h01C, 0, 32'h01C, 1, 32'h018, 32'h1000_0018));
        // Stall while the word from 0x20 returns, then release
        vecs.push_back(mk(32'h024, 1, 0, 1, 32'hDEAD_BEEF, 1, 32'h020, 0, 32'h020, 1, 32'h01C, 32'h1000_001C));
        vecs.push_back(mk(32'h024, 1, 0, 0, 32'h0,         0, 32'h020, 0, 32'h020, 1, 32'h01C, 32'h1000_001C));
        vecs.push_back(mk(32'h024, 0, 0, 0, 32'h0,         0, 32'h020, 0, 32'h020, 1, 32'h01C, 32'h1000_001C));
        vecs.push_back(mk(32'h028, 0, 0, 1, 32'h1000_0024, 1, 32'h024, 0, 32'h024, 1, 32'h020, 32'hDEAD_BEEF));
        vecs.push_back(mk(32'h02C, 0, 0, 1, 32'h1000_0028, 1, 32'h028, 0, 32'h028, 1, 32'h024, 32'h1000_0024));
        vecs.push_back(mk(32'h030, 0, 0, 1, 32'h1000_002C, 1, 32'h02C, 0, 32'h02C, 1, 32'h028, 32'h1000_0028));
        // Redirect to 0x100 while waiting at 0x30: drain then refetch
        vecs.push_back(mk(32'h034, 0, 0, 0, 32'h0,         1, 32'h030, 1, 32'h030, 1, 32'h02C, 32'h1000_002C));
        vecs.push_back(mk(32'h100, 0, 1, 0, 32'h0,         1, 32'h030, 1, 32'h030, 0, 32'h02C, NOP));
        vecs.push_back(mk(32'h104, 0, 0, 0, 32'h0,         1, 32'h030, 1, 32'h100, 0, 32'h100, NOP));
        vecs.push_back(mk(32'h104, 0, 0, 1, 32'hBAD0_0030, 1, 32'h030, 1, 32'h100, 0, 32'h100, NOP));
        vecs.push_back(mk(32'h104, 0, 0, 1, 32'h1000_0100, 1, 32'h100, 0, 32'h100, 0, 32'h100, NOP));
        vecs.push_back(mk(32'h108, 0, 0, 0, 32'h0,         1, 32'h104, 1, 32'h104, 1, 32'h100, 32'h1000_0100));
        // Flush in the same cycle as ready: word dropped, no drain
        vecs.push_back(mk(32'h200, 0, 1, 1, 32'hBAD0_0104, 1, 32'h104, 0, 32'h104, 0, 32'h100, NOP));
        vecs.push_back(mk(32'h204, 0, 0, 1, 32'h1000_0200, 1, 32'h200, 0, 32'h200, 0, 32'h200, NOP));
        // Stall into HOLD, then stall+flush together: flush wins, buffer dropped
        vecs.push_back(mk(32'h204, 1, 0, 1, 32'hCAFE_0204, 1, 32'h204, 0, 32'h204, 1, 32'h200, 32'h1000_0200));
        vecs.push_back(mk(32'h300, 1, 1, 0, 32'h0,         0, 32'h204, 0, 32'h204, 1, 32'h200, 32'h1000_0200));
        vecs.push_back(mk(32'h304, 0, 0, 1, 32'h1000_0300, 1, 32'h300, 0, 32'h300, 0, 32'h300, NOP));
        vecs.push_back(mk(32'h308, 0, 0, 0, 32'h0,         1, 32'h304, 1, 32'h304, 1, 32'h300, 32'h1000_0300));

        // Reset state
        reset_n = 1'b0;
        drive(32'h0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'b0, imem_req_o},   32'h0);
        chk("rst_valid", {31'b0, ifid_valid_o}, 32'h0);
        chk("rst_pc",    pc_o,                  32'h0);
        chk("rst_ifpc",  ifid_pc_o,             32'h0);
        chk("rst_instr", ifid_instr_o,          NOP);
        chk("rst_busy",  {31'b0, fetch_busy_o}, 32'h1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pc_next, vecs[i].stall, vecs[i].flush, vecs[i].ready, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   {31'b0, imem_req_o},   {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr_o,           vecs[i].e_addr);
            chk($sformatf("v%0d_busy", i),  {31'b0, fetch_busy_o}, {31'b0, vecs[i].e_busy});
            chk($sformatf("v%0d_pc", i),    pc_o,                  vecs[i].e_pc);
            chk($sformatf("v%0d_pc4", i),   pc_plus4_o,            vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d_valid", i), {31'b0, ifid_valid_o}, {31'b0, vecs[i].e_v});
            chk($sformatf("v%0d_ifpc", i),  ifid_pc_o,             vecs[i].e_ifpc);
            chk($sformatf("v%0d_instr", i), ifid_instr_o,          vecs[i].e_instr);
            @(posedge clk); #1;
        end

        // Mid-wait reset: request at 0x304 outstanding (table left state FETCH, waiting)
        drive(32'h308, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("mw_req_before", {31'b0, imem_req_o}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("mw_req",   {31'b0, imem_req_o},   32'h0);
        chk("mw_valid", {31'b0, ifid_valid_o}, 32'h0);
        chk("mw_pc",    pc_o,                  32'h0);
        chk("mw_busy",  {31'b0, fetch_busy_o}, 32'h1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(32'h4, 0, 0, 1, 32'h0);
        @(negedge clk);
        chk("mw_idle_req", {31'b0, imem_req_o}, 32'h0);
        @(posedge clk); #1;

        // Wrap-around: redirect to the last word, then fetch from it
        drive(32'hFFFF_FFFC, 0, 1, 1, 32'hBAD0_0000);
        @(negedge clk);
        chk("wr_req",  {31'b0, imem_req_o}, 32'h1);
        chk("wr_addr", imem_addr_o,         32'h0);
        @(posedge clk); #1;
        drive(32'h0, 0, 0, 1, 32'h1234_5678);
        @(negedge clk);
        chk("wr_pc",    pc_o,                  32'hFFFF_FFFC);
        chk("wr_pc4",   pc_plus4_o,            32'h0);
        chk("wr_addr2", imem_addr_o,           32'hFFFF_FFFC);
        chk("wr_valid", {31'b0, ifid_valid_o}, 32'h0);
        chk("wr_ifpc",  ifid_pc_o,             32'hFFFF_FFFC);
        @(posedge clk); #1;
        drive(32'h4, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("wr_pc_after",  pc_o,                  32'h0);
        chk("wr_valid2",    {31'b0, ifid_valid_o}, 32'h1);
        chk("wr_ifpc2",     ifid_pc_o,             32'hFFFF_FFFC);
        chk("wr_instr2",    ifid_instr_o,          32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
